// File: rtl/rx_pkg.sv
// Shared constants for the rx length controller.
// State encoding and Ethernet frame length limits.
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } rx_state_t;

  localparam int BYTES_PER_WORD = 8;
  localparam int MIN_LEN        = 64;
  localparam int MAX_LEN        = 1518;
  localparam int JUMBO_LEN      = 9018;
  localparam int VLAN_ADD       = 4;

endpackage

// File: rtl/rx_len_ctrl_cnt.sv
// Word counter: load sets to 1, en increments.
// Load wins over en; reset value is 1.
module rx_len_ctrl_cnt #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= WIDTH'(1);
    end else if (load) begin
      count <= WIDTH'(1);
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/rx_len_ctrl.sv
// Rx frame length controller: counts words per frame and
// reports byte length with runt/oversize flags.
module rx_len_ctrl #(
  parameter int WIDTH     = 11,
  parameter int MIN_LEN   = rx_pkg::MIN_LEN,
  parameter int MAX_LEN   = rx_pkg::MAX_LEN,
  parameter int JUMBO_LEN = rx_pkg::JUMBO_LEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_start,
  input  logic             rx_data_valid,
  input  logic             rx_end,
  input  logic [2:0]       rx_end_bytes,
  input  logic             rx_tagged,
  input  logic             cfg_jumbo_en,
  output logic             in_frame,
  output logic [WIDTH-1:0] word_cnt,
  output logic [15:0]      frame_len,
  output logic             len_valid,
  output logic             too_short,
  output logic             too_long,
  output logic             frame_abort
);

  import rx_pkg::*;

  rx_state_t  state, state_nxt;
  logic       load, en, latch, abort_set;
  logic       sat, sat_set, sat_flag;
  logic [2:0] end_bytes_q;
  logic       tagged_q;
  logic [15:0] bytes, len, limit;

  rx_len_ctrl_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .en    (en),
    .count (word_cnt)
  );

  assign sat      = (word_cnt == {WIDTH{1'b1}});
  assign in_frame = (state == RECV);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    en        = 1'b0;
    latch     = 1'b0;
    abort_set = 1'b0;
    sat_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_start) begin
          load      = 1'b1;
          latch     = rx_end;
          state_nxt = rx_end ? CHECK : RECV;
        end
      end
      RECV: begin
        en      = rx_data_valid & ~rx_start & ~sat;
        sat_set = rx_data_valid & ~rx_start & sat;
        if (rx_start) begin
          abort_set = 1'b1;
          load      = 1'b1;
          latch     = rx_end;
          state_nxt = rx_end ? CHECK : RECV;
        end else if (rx_end) begin
          latch     = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (rx_start) begin
          load      = 1'b1;
          latch     = rx_end;
          state_nxt = rx_end ? CHECK : RECV;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Length uses the counter before any same-edge reload.
  always_comb begin
    bytes = (end_bytes_q == 3'd0) ? 16'(BYTES_PER_WORD)
                                  : 16'(end_bytes_q);
    len   = ((16'(word_cnt) - 16'd1) << 3) + bytes;
    limit = (cfg_jumbo_en ? 16'(JUMBO_LEN) : 16'(MAX_LEN))
          + (tagged_q ? 16'(VLAN_ADD) : 16'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_flag    <= 1'b0;
      end_bytes_q <= 3'd0;
      tagged_q    <= 1'b0;
    end else begin
      if (load) begin
        sat_flag <= 1'b0;
      end else if (sat_set) begin
        sat_flag <= 1'b1;
      end
      if (latch) begin
        end_bytes_q <= rx_end_bytes;
        tagged_q    <= rx_tagged;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_len   <= 16'd0;
      too_short   <= 1'b0;
      too_long    <= 1'b0;
      len_valid   <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      len_valid   <= (state == CHECK);
      frame_abort <= abort_set;
      if (state == CHECK) begin
        frame_len <= len;
        too_short <= (len < 16'(MIN_LEN));
        too_long  <= (len > limit) | sat_flag;
      end
    end
  end

endmodule

// File: tb/tb_rx_len_ctrl.sv
// Directed bench for rx_len_ctrl (WIDTH 11 and WIDTH 4
// instances share stimulus).
module tb_rx_len_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_start, rx_data_valid, rx_end;
  logic [2:0]  rx_end_bytes;
  logic        rx_tagged, cfg_jumbo_en;

  logic        in_frame, len_valid, too_short, too_long;
  logic        frame_abort;
  logic [10:0] word_cnt;
  logic [15:0] frame_len;

  logic        in_frame4, len_valid4, too_short4, too_long4;
  logic        frame_abort4;
  logic [3:0]  word_cnt4;
  logic [15:0] frame_len4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rx_len_ctrl #(.WIDTH(11)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_start      (rx_start),
    .rx_data_valid (rx_data_valid),
    .rx_end        (rx_end),
    .rx_end_bytes  (rx_end_bytes),
    .rx_tagged     (rx_tagged),
    .cfg_jumbo_en  (cfg_jumbo_en),
    .in_frame      (in_frame),
    .word_cnt      (word_cnt),
    .frame_len     (frame_len),
    .len_valid     (len_valid),
    .too_short     (too_short),
    .too_long      (too_long),
    .frame_abort   (frame_abort)
  );

  rx_len_ctrl #(.WIDTH(4)) dut4 (
    .clk           (clk),
    .reset         (reset),
    .rx_start      (rx_start),
    .rx_data_valid (rx_data_valid),
    .rx_end        (rx_end),
    .rx_end_bytes  (rx_end_bytes),
    .rx_tagged     (rx_tagged),
    .cfg_jumbo_en  (cfg_jumbo_en),
    .in_frame      (in_frame4),
    .word_cnt      (word_cnt4),
    .frame_len     (frame_len4),
    .len_valid     (len_valid4),
    .too_short     (too_short4),
    .too_long      (too_long4),
    .frame_abort   (frame_abort4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rx_start      = 1'b0;
    rx_data_valid = 1'b0;
    rx_end        = 1'b0;
  endtask

  task automatic word(input logic s, input logic e,
                      input logic [2:0] eb);
    rx_start      = s;
    rx_data_valid = 1'b1;
    rx_end        = e;
    rx_end_bytes  = eb;
    tick();
  endtask

  // n words starting with rx_start, last word carries rx_end
  task automatic send_frame(input int n, input logic [2:0] eb,
                            input logic tg);
    rx_tagged = tg;
    for (int i = 1; i <= n; i++) begin
      word(i == 1, i == n, eb);
    end
    idle_in();
  endtask

  initial begin
    reset         = 1'b1;
    cfg_jumbo_en  = 1'b0;
    rx_tagged     = 1'b0;
    rx_end_bytes  = 3'd0;
    idle_in();
    #12;
    chk("rst_in_frame", 32'(in_frame), 0);
    chk("rst_word_cnt", 32'(word_cnt), 1);
    chk("rst_frame_len", 32'(frame_len), 0);
    chk("rst_len_valid", 32'(len_valid), 0);
    chk("rst_flags", {too_short, too_long, frame_abort}, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // 64-byte frame
    rx_tagged = 1'b0;
    word(1'b1, 1'b0, 3'd0);
    chk("f64_in_frame", 32'(in_frame), 1);
    chk("f64_cnt_first", 32'(word_cnt), 1);
    for (int i = 2; i <= 8; i++) word(1'b0, i == 8, 3'd0);
    idle_in();
    chk("f64_cnt_check", 32'(word_cnt), 8);
    chk("f64_no_early_valid", 32'(len_valid), 0);
    tick();
    chk("f64_len_valid", 32'(len_valid), 1);
    chk("f64_frame_len", 32'(frame_len), 64);
    chk("f64_flags", {too_short, too_long}, 0);
    tick();
    chk("f64_valid_pulse", 32'(len_valid), 0);
    chk("f64_len_hold", 32'(frame_len), 64);

    // 60-byte runt
    send_frame(8, 3'd4, 1'b0);
    tick();
    chk("f60_len_valid", 32'(len_valid), 1);
    chk("f60_frame_len", 32'(frame_len), 60);
    chk("f60_too_short", 32'(too_short), 1);
    chk("f60_too_long", 32'(too_long), 0);

    // 1519 bytes: oversize untagged, legal tagged or jumbo
    send_frame(190, 3'd7, 1'b0);
    tick();
    chk("f1519_frame_len", 32'(frame_len), 1519);
    chk("f1519_too_long", 32'(too_long), 1);
    chk("f1519_too_short", 32'(too_short), 0);
    send_frame(190, 3'd7, 1'b1);
    tick();
    chk("f1519_tag_valid", 32'(len_valid), 1);
    chk("f1519_tag_too_long", 32'(too_long), 0);
    send_frame(190, 3'd7, 1'b0);
    cfg_jumbo_en = 1'b1;
    tick();
    chk("f1519_jumbo_too_long", 32'(too_long), 0);
    chk("f1519_jumbo_len", 32'(frame_len), 1519);
    cfg_jumbo_en = 1'b0;
    tick();

    // single-word frame then back-to-back 4-word frame
    rx_tagged = 1'b0;
    word(1'b1, 1'b1, 3'd0);
    chk("single_not_in_frame", 32'(in_frame), 0);
    word(1'b1, 1'b0, 3'd0);
    chk("single_len_valid", 32'(len_valid), 1);
    chk("single_frame_len", 32'(frame_len), 8);
    chk("single_too_short", 32'(too_short), 1);
    chk("b2b_cnt_restart", 32'(word_cnt), 1);
    chk("b2b_in_frame", 32'(in_frame), 1);
    for (int i = 2; i <= 4; i++) word(1'b0, i == 4, 3'd0);
    idle_in();
    tick();
    chk("b2b_len_valid", 32'(len_valid), 1);
    chk("b2b_frame_len", 32'(frame_len), 32);
    tick();

    // abort then 10-word frame with gaps
    for (int i = 1; i <= 5; i++) word(i == 1, 1'b0, 3'd0);
    chk("abort_pre_cnt", 32'(word_cnt), 5);
    word(1'b1, 1'b0, 3'd0);
    chk("abort_pulse", 32'(frame_abort), 1);
    chk("abort_no_valid", 32'(len_valid), 0);
    chk("abort_cnt_reload", 32'(word_cnt), 1);
    for (int i = 2; i <= 10; i++) begin
      if (i == 4 || i == 7) begin
        idle_in();
        tick();
        chk("gap_cnt_hold", 32'(word_cnt), 32'(i - 1));
      end
      word(1'b0, i == 10, 3'd0);
      if (i == 2) chk("abort_pulse_end", 32'(frame_abort), 0);
    end
    idle_in();
    chk("f80_cnt", 32'(word_cnt), 10);
    tick();
    chk("f80_len_valid", 32'(len_valid), 1);
    chk("f80_frame_len", 32'(frame_len), 80);
    chk("f80_flags", {too_short, too_long}, 0);
    tick();

    // 20 words: WIDTH 4 saturates at 15, WIDTH 11 does not
    send_frame(20, 3'd0, 1'b0);
    chk("sat_cnt4", 32'(word_cnt4), 15);
    chk("sat_cnt11", 32'(word_cnt), 20);
    tick();
    chk("sat_valid4", 32'(len_valid4), 1);
    chk("sat_too_long4", 32'(too_long4), 1);
    chk("sat_len4", 32'(frame_len4), 120);
    chk("sat_len11", 32'(frame_len), 160);
    chk("sat_too_long11", 32'(too_long), 0);
    tick();

    // rx_end in IDLE is ignored
    rx_end = 1'b1;
    rx_data_valid = 1'b1;
    tick();
    idle_in();
    tick();
    chk("stray_end_valid", 32'(len_valid), 0);
    chk("stray_end_in_frame", 32'(in_frame), 0);

    // reset mid-frame discards the frame
    for (int i = 1; i <= 3; i++) word(i == 1, 1'b0, 3'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_in_frame", 32'(in_frame), 0);
    chk("rst_mid_word_cnt", 32'(word_cnt), 1);
    rx_end = 1'b1;
    tick();
    reset = 1'b0;
    idle_in();
    tick();
    chk("rst_mid_no_valid", 32'(len_valid), 0);
    tick();
    chk("rst_mid_no_valid2", 32'(len_valid), 0);
    chk("rst_mid_len", 32'(frame_len), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
